// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: owner encodings, lock states
// and default geometry.
package data_mem_arbiter_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 8;
  localparam int MAX_LOCK_DEF = 8;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CORE = 2'b01;
  localparam logic [1:0] OWN_HOST = 2'b10;

  // Encoding of the last_gnt register: which side won the most recent grant.
  localparam logic LAST_CORE = 1'b0;
  localparam logic LAST_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_CORE,
    LOCK_HOST
  } lock_state_t;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker. Bit 0 is the core, bit 1 the host;
// a non-zero i_force mask restricts which side may be granted.
module data_mem_arbiter_rr_pick2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic [1:0] i_force,
  output logic [1:0] o_gnt
);

  logic [1:0] w_elig;

  assign w_elig = (i_force != OWN_NONE) ? (i_req & i_force) : i_req;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    o_gnt = w_elig;
    if (w_elig == 2'b11) begin
      o_gnt = (i_last == LAST_HOST) ? OWN_CORE : OWN_HOST;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core and
// the host port. Define DATA_MEM_ARB_LOCK_EN to compile in the burst lock FSM.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_lock,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  logic [1:0]        w_pick;
  logic [1:0]        w_force;
  logic              w_core_gnt;
  logic              w_host_gnt;
  logic              r_last;
  logic              r_core_rvalid;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  data_mem_arbiter_rr_pick2 u_rr_pick2 (
    .i_req   ({host_req, core_req}),
    .i_last  (r_last),
    .i_force (w_force),
    .o_gnt   (w_pick)
  );

  // A cycle with reset asserted performs no access at all.
  assign w_core_gnt = w_pick[0] & ~rst;
  assign w_host_gnt = w_pick[1] & ~rst;

  assign core_gnt    = w_core_gnt;
  assign host_gnt    = w_host_gnt;
  assign owner       = {w_host_gnt, w_core_gnt};
  assign core_rdata  = r_core_rdata;
  assign host_rdata  = r_host_rdata;
  assign core_rvalid = r_core_rvalid;
  assign host_rvalid = r_host_rvalid;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (w_host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last        <= LAST_HOST;
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_core_rdata  <= '0;
      r_host_rdata  <= '0;
    end else begin
      r_core_rvalid <= w_core_gnt & ~core_we;
      r_host_rvalid <= w_host_gnt & ~host_we;
      if (w_core_gnt & ~core_we) r_core_rdata <= mem_rdata;
      if (w_host_gnt & ~host_we) r_host_rdata <= mem_rdata;
      if (w_core_gnt)      r_last <= LAST_CORE;
      else if (w_host_gnt) r_last <= LAST_HOST;
    end
  end

`ifdef DATA_MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  lock_state_t      r_state;
  lock_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_lock_cnt_nxt;

  assign w_force = (r_state == LOCK_CORE) ? OWN_CORE :
                   (r_state == LOCK_HOST) ? OWN_HOST : OWN_NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // The grant that reaches MAX_LOCK releases the lock; last_gnt then favours the other side.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      IDLE: begin
        if (w_core_gnt && core_lock && (MAX_LOCK > 1)) begin
          w_state_nxt    = LOCK_CORE;
          w_lock_cnt_nxt = CNT_W'(1);
        end else if (w_host_gnt && host_lock && (MAX_LOCK > 1)) begin
          w_state_nxt    = LOCK_HOST;
          w_lock_cnt_nxt = CNT_W'(1);
        end
      end
      LOCK_CORE: begin
        if (!core_lock || (w_core_gnt && r_lock_cnt == CNT_W'(MAX_LOCK - 1))) begin
          w_state_nxt    = IDLE;
          w_lock_cnt_nxt = '0;
        end else if (w_core_gnt) begin
          w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
        end
      end
      LOCK_HOST: begin
        if (!host_lock || (w_host_gnt && r_lock_cnt == CNT_W'(MAX_LOCK - 1))) begin
          w_state_nxt    = IDLE;
          w_lock_cnt_nxt = '0;
        end else if (w_host_gnt) begin
          w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end
`else
  logic w_lock_unused;

  assign w_force       = OWN_NONE;
  assign w_lock_unused = core_lock | host_lock | (MAX_LOCK == 0);
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a reference memory and per-side read
// scoreboards; expectations follow DATA_MEM_ARB_LOCK_EN when it is defined.
module tb_data_mem_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_req, core_we, core_lock;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              host_req, host_we, host_lock;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              core_gnt, host_gnt, core_rvalid, host_rvalid;
  logic [DATA_W-1:0] core_rdata, host_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        owner;

  logic [DATA_W-1:0] mem     [32];
  logic [DATA_W-1:0] ref_mem [32];
  logic [DATA_W-1:0] core_q[$];
  logic [DATA_W-1:0] host_q[$];
  logic              exp_crv = 1'b0;
  logic              exp_hrv = 1'b0;
  int                checks  = 0;
  int                errors  = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_lock   (core_lock),
    .core_gnt    (core_gnt),
    .core_rdata  (core_rdata),
    .core_rvalid (core_rvalid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_lock   (host_lock),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .owner       (owner)
  );

  // External single-port memory: combinational read, write at the clock edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic lock);
    core_req = req; core_we = we; core_addr = addr; core_wdata = wdata; core_lock = lock;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic lock);
    host_req = req; host_we = we; host_addr = addr; host_wdata = wdata; host_lock = lock;
  endtask

  // One clock cycle: check last cycle's read returns, then this cycle's grant and mux.
  task automatic step(input string tag, input logic ecg, input logic ehg);
    logic [DATA_W-1:0] e_data;
    @(negedge clk);
    check({tag, ".core_rvalid"}, core_rvalid, exp_crv);
    if (exp_crv && core_q.size() > 0) begin
      e_data = core_q.pop_front();
      check({tag, ".core_rdata"}, core_rdata, e_data);
    end
    check({tag, ".host_rvalid"}, host_rvalid, exp_hrv);
    if (exp_hrv && host_q.size() > 0) begin
      e_data = host_q.pop_front();
      check({tag, ".host_rdata"}, host_rdata, e_data);
    end
    check({tag, ".owner"}, owner, {ehg, ecg});
    check({tag, ".gnt"}, {host_gnt, core_gnt}, {ehg, ecg});
    check({tag, ".mem_we"}, mem_we, (ecg & core_we) | (ehg & host_we));
    check({tag, ".mem_addr"}, mem_addr, ecg ? core_addr : (ehg ? host_addr : '0));
    check({tag, ".mem_wdata"}, mem_wdata, ecg ? core_wdata : (ehg ? host_wdata : '0));
    exp_crv = ecg & ~core_we;
    exp_hrv = ehg & ~host_we;
    if (exp_crv) core_q.push_back(ref_mem[core_addr]);
    if (exp_hrv) host_q.push_back(ref_mem[host_addr]);
    if (ecg && core_we) ref_mem[core_addr] = core_wdata;
    if (ehg && host_we) ref_mem[host_addr] = host_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = DATA_W'(i * 7 + 3);
      ref_mem[i] = DATA_W'(i * 7 + 3);
    end
    rst = 1'b1;
    set_core(0, 0, 0, 0, 0);
    set_host(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.core_rdata", core_rdata, 0);
    check("reset.host_rdata", host_rdata, 0);

    // Uncontested host write then core read-back.
    set_host(1, 1, 5'd3, 8'h5A, 0);
    step("t1_hwr", 0, 1);
    set_host(0, 0, 0, 0, 0);
    set_core(1, 0, 5'd3, 0, 0);
    step("t1_crd", 1, 0);
    set_core(0, 0, 0, 0, 0);
    step("t1_idle", 0, 0);
    check("t1_readback", core_rdata, 8'h5A);

    // Sustained contention from reset: core, host, core, host.
    rst = 1'b1;
    step("t2_rst", 0, 0);
    rst = 1'b0;
    set_core(1, 0, 5'd1, 0, 0);
    set_host(1, 0, 5'd2, 0, 0);
    step("t2_c0", 1, 0);
    step("t2_h0", 0, 1);
    step("t2_c1", 1, 0);
    step("t2_h1", 0, 1);
    set_core(0, 0, 0, 0, 0);
    set_host(0, 0, 0, 0, 0);
    step("t2_idle", 0, 0);

    // Same-cycle core write and host read of addr 7: core first, host sees new data.
    set_core(1, 1, 5'd7, 8'h11, 0);
    set_host(1, 0, 5'd7, 0, 0);
    step("t3_cwr", 1, 0);
    set_core(0, 0, 0, 0, 0);
    step("t3_hrd", 0, 1);
    set_host(0, 0, 0, 0, 0);
    step("t3_idle", 0, 0);
    check("t3_host_data", host_rdata, 8'h11);

    // Host lock held with continuous contention.
    set_host(1, 0, 5'd4, 0, 1);
    step("t4_h_first", 0, 1);
    set_core(1, 0, 5'd5, 0, 0);
    for (int i = 0; i < 8; i++) begin
`ifdef DATA_MEM_ARB_LOCK_EN
      step($sformatf("t4_lock%0d", i), i == 7, i != 7);
`else
      step($sformatf("t4_rr%0d", i), i % 2 == 0, i % 2 == 1);
`endif
    end
    set_core(0, 0, 0, 0, 0);
    set_host(0, 0, 0, 0, 0);
    step("t4_idle", 0, 0);

    // Host lock dropped during its third grant: core wins cycle 4.
    set_host(1, 0, 5'd6, 0, 1);
    step("t5_c1", 0, 1);
    set_core(1, 0, 5'd8, 0, 0);
`ifdef DATA_MEM_ARB_LOCK_EN
    step("t5_c2", 0, 1);
`else
    step("t5_c2", 1, 0);
`endif
    host_lock = 1'b0;
`ifdef DATA_MEM_ARB_LOCK_EN
    step("t5_c3", 0, 1);
`else
    step("t5_c3", 0, 1);
`endif
    step("t5_c4", 1, 0);
    set_core(0, 0, 0, 0, 0);
    set_host(0, 0, 0, 0, 0);
    step("t5_idle", 0, 0);

    // Reset during a pending host write: write dropped, rvalid cleared, core wins tie.
    set_core(1, 0, 5'd9, 0, 0);
    step("t6_crd", 1, 0);
    set_core(0, 0, 0, 0, 0);
    set_host(1, 1, 5'd9, 8'hEE, 0);
    rst = 1'b1;
    step("t6_rst", 0, 0);
    rst = 1'b0;
    check("t6_rst_core_rdata", core_rdata, 0);
    check("t6_rst_host_rdata", host_rdata, 0);
    set_core(1, 0, 5'd9, 0, 0);
    set_host(1, 0, 5'd9, 0, 0);
    step("t6_tie", 1, 0);
    set_core(0, 0, 0, 0, 0);
    step("t6_hrd", 0, 1);
    set_host(0, 0, 0, 0, 0);
    step("t6_idle", 0, 0);
    check("t6_addr9_kept", host_rdata, ref_mem[9]);

    check("core_q_drained", core_q.size(), 0);
    check("host_q_drained", host_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
